// File: rtl/fsrcnn_pkg.sv
// Shared definitions for the PE array tile datapath: state encoding seen on
// top_level_state, default address widths and the PE array pipeline depth.
package fsrcnn_pkg;
  localparam int PB_AW_D = 8;
  localparam int WB_AW_D = 10;
  localparam int DB_AW_D = 12;
  localparam int CNT_W_D = 8;
  localparam int PE_LAT  = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CFG     = 3'd1,
    ST_FETCH   = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;
endpackage

// File: rtl/pe_tile_scheduler_if.sv
// Scheduler <-> PE array / buffer read bundle. The scheduler is the master.
interface pe_tile_scheduler_if
  import fsrcnn_pkg::*;
#(
  parameter int PB_AW = PB_AW_D,
  parameter int WB_AW = WB_AW_D,
  parameter int DB_AW = DB_AW_D,
  parameter int CNT_W = CNT_W_D
) ();
  logic [2:0]       top_level_state;
  logic [CNT_W-1:0] tile_size;
  logic [PB_AW-1:0] pb_addr;
  logic             new_tile;
  logic             wb_re;
  logic [WB_AW-1:0] wb_ra;
  logic             db_re;
  logic [DB_AW-1:0] db_ra;
  logic             pe_finish_flg;

  modport master (
    output top_level_state, tile_size, pb_addr, new_tile,
    output wb_re, wb_ra, db_re, db_ra,
    input  pe_finish_flg
  );
  modport slave (
    input  top_level_state, tile_size, pb_addr, new_tile,
    input  wb_re, wb_ra, db_re, db_ra,
    output pe_finish_flg
  );
endinterface

// File: rtl/loop_addr_gen.sv
// ci/co loop counters and running-offset address generators; all products
// co*(ts+1), ci*(ts+1) and the linear group index are kept as running sums.
module loop_addr_gen
  import fsrcnn_pkg::*;
#(
  parameter int PB_AW = PB_AW_D,
  parameter int WB_AW = WB_AW_D,
  parameter int DB_AW = DB_AW_D,
  parameter int CNT_W = CNT_W_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_fetch,
  input  logic             i_pix_step,
  input  logic             i_grp_done,
  input  logic [CNT_W-1:0] i_ts,
  input  logic [CNT_W-1:0] i_ci_num,
  input  logic [CNT_W-1:0] i_co_num,
  input  logic [PB_AW-1:0] i_pb_base,
  input  logic [WB_AW-1:0] i_wb_base,
  input  logic [DB_AW-1:0] i_db_base,
  output logic             o_first_ci,
  output logic             o_last_ci,
  output logic             o_last_co,
  output logic [PB_AW-1:0] o_pb_addr,
  output logic [WB_AW-1:0] o_wb_addr,
  output logic [DB_AW-1:0] o_db_row,
  output logic [DB_AW-1:0] o_db_ptr
);
  logic [CNT_W-1:0] r_ci, r_co;
  logic [PB_AW-1:0] r_pb;
  logic [WB_AW-1:0] r_wb;
  logic [DB_AW-1:0] r_db_base, r_db_row, r_db_ptr;
  logic [CNT_W:0]   w_ts_p1;

  assign w_ts_p1 = {1'b0, i_ts} + (CNT_W+1)'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ci      <= '0;
      r_co      <= '0;
      r_pb      <= '0;
      r_wb      <= '0;
      r_db_base <= '0;
      r_db_row  <= '0;
      r_db_ptr  <= '0;
    end else begin
      if (i_load) begin
        r_ci      <= '0;
        r_co      <= '0;
        r_pb      <= i_pb_base;
        r_wb      <= i_wb_base;
        r_db_base <= i_db_base;
        r_db_row  <= i_db_base;
      end else if (i_grp_done) begin
        // weight words are stored group-linear: one step per (co,ci) pair
        r_wb <= r_wb + WB_AW'(1);
        if (!o_last_ci) begin
          r_ci     <= r_ci + CNT_W'(1);
          r_db_row <= r_db_row + DB_AW'(w_ts_p1);
        end else begin
          r_ci     <= '0;
          r_db_row <= r_db_base;
          if (!o_last_co) begin
            r_co <= r_co + CNT_W'(1);
            r_pb <= r_pb + PB_AW'(w_ts_p1);
          end
        end
      end
      if (i_fetch)         r_db_ptr <= r_db_row + DB_AW'(1);
      else if (i_pix_step) r_db_ptr <= r_db_ptr + DB_AW'(1);
    end
  end

  assign o_first_ci = (r_ci == '0);
  assign o_last_ci  = (r_ci >= i_ci_num);
  assign o_last_co  = (r_co >= i_co_num);
  assign o_pb_addr  = r_pb;
  assign o_wb_addr  = r_wb;
  assign o_db_row   = r_db_row;
  assign o_db_ptr   = r_db_ptr;
endmodule

// File: rtl/pe_tile_scheduler.sv
// Tile sequencer for the 16x4 PE adder-tree array: walks co/ci groups through
// CFG -> FETCH -> COMPUTE and cross-checks pe_finish_flg against its own count.
module pe_tile_scheduler
  import fsrcnn_pkg::*;
#(
  parameter int PB_AW = PB_AW_D,
  parameter int WB_AW = WB_AW_D,
  parameter int DB_AW = DB_AW_D,
  parameter int CNT_W = CNT_W_D
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_W-1:0]    cfg_tile_size,
  input  logic [CNT_W-1:0]    cfg_ci_num,
  input  logic [CNT_W-1:0]    cfg_co_num,
  input  logic [PB_AW-1:0]    cfg_pb_base,
  input  logic [WB_AW-1:0]    cfg_wb_base,
  input  logic [DB_AW-1:0]    cfg_db_base,
  pe_tile_scheduler_if.master pe,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam logic [CNT_W+1:0] LAT = (CNT_W+2)'(PE_LAT);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_ts, r_ci_num, r_co_num;
  logic [CNT_W+1:0] r_pix;  // doubles as cc: both restart at COMPUTE entry
  logic             r_err;

  logic w_load, w_fetch, w_pix_step, w_grp_done, w_err_set;
  logic w_pix_live, w_at_end, w_in_grp, w_wb_re;
  logic w_first_ci, w_last_ci, w_last_co;
  logic [PB_AW-1:0] w_pb;
  logic [WB_AW-1:0] w_wb;
  logic [DB_AW-1:0] w_db_row, w_db_ptr;

  loop_addr_gen #(.PB_AW(PB_AW), .WB_AW(WB_AW), .DB_AW(DB_AW), .CNT_W(CNT_W)) u_gen (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_fetch    (w_fetch),
    .i_pix_step (w_pix_step),
    .i_grp_done (w_grp_done),
    .i_ts       (r_ts),
    .i_ci_num   (r_ci_num),
    .i_co_num   (r_co_num),
    .i_pb_base  (cfg_pb_base),
    .i_wb_base  (cfg_wb_base),
    .i_db_base  (cfg_db_base),
    .o_first_ci (w_first_ci),
    .o_last_ci  (w_last_ci),
    .o_last_co  (w_last_co),
    .o_pb_addr  (w_pb),
    .o_wb_addr  (w_wb),
    .o_db_row   (w_db_row),
    .o_db_ptr   (w_db_ptr)
  );

  assign w_pix_live = (r_state == ST_COMPUTE) && (r_pix < {2'b00, r_ts});
  assign w_at_end   = (r_pix == ({2'b00, r_ts} + LAT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_ts     <= '0;
      r_ci_num <= '0;
      r_co_num <= '0;
      r_pix    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_ts     <= cfg_tile_size;
        r_ci_num <= cfg_ci_num;
        r_co_num <= cfg_co_num;
      end
      if (w_fetch)                     r_pix <= '0;
      else if (r_state == ST_COMPUTE) r_pix <= r_pix + (CNT_W+2)'(1);
      if (w_load)         r_err <= 1'b0;
      else if (w_err_set) r_err <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_fetch     = 1'b0;
    w_pix_step  = 1'b0;
    w_grp_done  = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_IDLE: if (start) begin
        w_load      = 1'b1;
        w_state_nxt = ST_CFG;
      end
      ST_CFG: w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        w_fetch     = 1'b1;
        w_state_nxt = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        w_pix_step = w_pix_live;
        // an early or missing finish is flagged but never stalls the sequence
        if (pe.pe_finish_flg || w_at_end) begin
          w_grp_done  = 1'b1;
          w_err_set   = !(pe.pe_finish_flg && w_at_end);
          w_state_nxt = (w_last_ci && w_last_co) ? ST_DONE : ST_CFG;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: begin
        w_err_set   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_in_grp = (r_state == ST_CFG) || (r_state == ST_FETCH) || (r_state == ST_COMPUTE);
  assign w_wb_re  = (r_state == ST_FETCH);

  assign pe.top_level_state = r_state;
  assign pe.tile_size       = r_ts;
  assign pe.pb_addr         = w_in_grp ? w_pb : '0;
  assign pe.new_tile        = w_in_grp && w_first_ci;
  assign pe.wb_re           = w_wb_re;
  assign pe.wb_ra           = w_wb_re ? w_wb : '0;
  assign pe.db_re           = w_wb_re || w_pix_live;
  assign pe.db_ra           = w_wb_re ? w_db_row : (w_pix_live ? w_db_ptr : '0);

  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_DONE);
  assign err  = r_err;
endmodule

// File: tb/tb_pe_tile_scheduler.sv
// Scoreboard bench: each run pushes the reference read/done sequence, a
// negedge monitor pops and compares whenever the scheduler issues something.
module tb_pe_tile_scheduler;
  typedef struct {
    int kind;  // 0 weight fetch, 1 data read, 2 done
    int a;
    int b;
    int c;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  cfg_ts, cfg_ci, cfg_co, cfg_pb;
  logic [9:0]  cfg_wb;
  logic [11:0] cfg_db;
  logic        busy, done, err;

  int  cyc = 0;
  int  n_cmp = 0;
  int  n_fail = 0;
  int  fin_at = 0;
  int  pe_cc = 0;
  logic prev_comp = 1'b0;
  ev_t exp_q[$];

  pe_tile_scheduler_if pe_if ();

  pe_tile_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_tile_size (cfg_ts),
    .cfg_ci_num    (cfg_ci),
    .cfg_co_num    (cfg_co),
    .cfg_pb_base   (cfg_pb),
    .cfg_wb_base   (cfg_wb),
    .cfg_db_base   (cfg_db),
    .pe            (pe_if),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // PE array stand-in: raises finish on its own cycle count within COMPUTE
  always @(negedge clk) begin
    int n;
    n = (prev_comp && pe_if.top_level_state == 3'd3) ? pe_cc + 1 : 0;
    if (!rst) begin
      pe_cc <= 0;
      prev_comp <= 1'b0;
      pe_if.pe_finish_flg <= 1'b0;
    end else begin
      pe_cc <= n;
      prev_comp <= (pe_if.top_level_state == 3'd3);
      pe_if.pe_finish_flg <= (pe_if.top_level_state == 3'd3) && (n == fin_at);
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, got, exp);
    end
  endtask

  task automatic check_ev(input int kind, input int a, input int b, input int c, input string nm);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected event a=%0d b=%0d c=%0d", nm, a, b, c);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.a != a || e.b != b || e.c != c) begin
        n_fail++;
        $display("FAIL %s: got kind=%0d a=%0d b=%0d c=%0d, want kind=%0d a=%0d b=%0d c=%0d",
                 nm, kind, a, b, c, e.kind, e.a, e.b, e.c);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (pe_if.wb_re)
        check_ev(0, int'(pe_if.wb_ra), int'(pe_if.pb_addr),
                 int'(pe_if.tile_size) * 2 + int'(pe_if.new_tile), "wb_fetch");
      if (pe_if.db_re) check_ev(1, int'(pe_if.db_ra), 0, 0, "db_read");
      if (done)        check_ev(2, cyc, int'(err), int'(busy), "done");
    end
  end

  // Reference: nested co/ci loops, plain address arithmetic, cycle cost per group
  task automatic push_run(input int ts, input int cin, input int con, input int pbb,
                          input int wbb, input int dbb, input int fin, input int s);
    int ex, npix, t;
    ev_t e;
    ex   = (fin < ts + 3) ? fin : ts + 3;
    npix = (ts < ex + 1) ? ts : ex + 1;
    t    = 0;
    for (int co = 0; co <= con; co++)
      for (int ci = 0; ci <= cin; ci++) begin
        e = '{0, (wbb + co * (cin + 1) + ci) % 1024, (pbb + co * (ts + 1)) % 256,
              ts * 2 + ((ci == 0) ? 1 : 0)};
        exp_q.push_back(e);
        for (int p = 0; p <= npix; p++) begin
          e = '{1, (dbb + ci * (ts + 1) + p) % 4096, 0, 0};
          exp_q.push_back(e);
        end
        t += 3 + ex;
      end
    e = '{2, s + t, (fin != ts + 3) ? 1 : 0, 1};
    exp_q.push_back(e);
  endtask

  task automatic recover();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst = 1'b1;
  endtask

  task automatic run(input int ts, input int cin, input int con, input int pbb,
                     input int wbb, input int dbb, input int fin, input bit poke);
    @(negedge clk);
    cfg_ts = 8'(ts); cfg_ci = 8'(cin); cfg_co = 8'(con);
    cfg_pb = 8'(pbb); cfg_wb = 10'(wbb); cfg_db = 12'(dbb);
    fin_at = fin;
    push_run(ts, cin, con, pbb, wbb, dbb, fin, cyc + 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_ts = 8'($urandom); cfg_ci = 8'($urandom); cfg_co = 8'($urandom);
    cfg_pb = 8'($urandom); cfg_wb = 10'($urandom); cfg_db = 12'($urandom);
    if (poke) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int k = 0; k < 6000 && exp_q.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL run_timeout: %0d events outstanding, want 0", exp_q.size());
      recover();
    end else begin
      @(negedge clk);
      chk("busy_after_done", int'(busy), 0);
      chk("err_held", int'(err), (fin != ts + 3) ? 1 : 0);
    end
  endtask

  task automatic reset_mid();
    int s;
    @(negedge clk);
    cfg_ts = 8'd3; cfg_ci = 8'd1; cfg_co = 8'd0;
    cfg_pb = 8'd0; cfg_wb = 10'd0; cfg_db = 12'd0;
    fin_at = 6;
    s = cyc + 1;
    push_run(3, 1, 0, 0, 0, 0, 6, s);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20 && cyc < s + 4; k++) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_state", int'(pe_if.top_level_state), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_re", int'({pe_if.wb_re, pe_if.db_re}), 0);
    chk("rst_mid_err", int'(err), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0;
    cfg_ts = '0; cfg_ci = '0; cfg_co = '0; cfg_pb = '0; cfg_wb = '0; cfg_db = '0;
    repeat (3) @(negedge clk);
    chk("rst_state", int'(pe_if.top_level_state), 0);
    chk("rst_outs", int'({busy, done, err, pe_if.new_tile, pe_if.wb_re, pe_if.db_re}), 0);
    chk("rst_tile_size", int'(pe_if.tile_size), 0);
    chk("rst_pb_addr", int'(pe_if.pb_addr), 0);
    rst = 1'b1;

    run(3, 0, 0, 0, 0, 0, 6, 1'b0);        // single group
    run(7, 2, 0, 0, 0, 0, 10, 1'b0);       // ci accumulate
    run(15, 1, 1, 250, 0, 0, 18, 1'b0);    // co loop with pb wrap
    run(3, 0, 0, 0, 0, 0, 2, 1'b0);        // early finish
    reset_mid();
    run(3, 1, 0, 5, 7, 9, 6, 1'b0);        // clean run after abort
    run(5, 1, 1, 17, 1000, 4090, 8, 1'b1); // start while busy
    run(0, 0, 0, 200, 3, 4095, 3, 1'b0);   // minimal tile
    run(255, 0, 1, 9, 1023, 4000, 258, 1'b0);
    run(4, 0, 0, 0, 0, 0, 12, 1'b0);       // missing finish
    for (int r = 0; r < 10; r++) begin
      int ts, cin, con, fin;
      ts  = int'($urandom_range(20));
      cin = int'($urandom_range(3));
      con = int'($urandom_range(2));
      fin = ts + 3;
      if ($urandom_range(3) == 0) begin
        fin = int'($urandom_range(ts + 6));
        if (fin == ts + 3) fin = ts + 4;
      end
      run(ts, cin, con, int'($urandom_range(255)), int'($urandom_range(1023)),
          int'($urandom_range(4095)), fin, $urandom_range(1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
